// File: rtl/cvt_pkg.sv
// cvt_pkg: shared types and constants for the int-to-float issue/collect slice.
//   UNIT_LAT_ITOF : latency of the itof converter (input valid -> out_valid)
//   TAG_W_DFLT    : default destination tag width
//   tag_t         : destination tag
//   cvt_rsp_t     : response FIFO entry {data, tag}
package cvt_pkg;

    localparam int UNIT_LAT_ITOF = 2;
    localparam int TAG_W_DFLT    = 5;

    typedef logic [TAG_W_DFLT-1:0] tag_t;

    typedef struct packed {
        logic [31:0] data;
        tag_t        tag;
    } cvt_rsp_t;

endpackage

// File: rtl/cvt_rsp_fifo.sv
// cvt_rsp_fifo: synchronous first-word-fall-through FIFO for converter results.
// Ports:
//   i_clk, i_rstn      : clock, synchronous active-low reset
//   i_push, i_din      : write strobe and entry
//   i_pop              : consume head (ignored when empty)
//   o_valid, o_dout    : FIFO not empty, head entry (combinational)
//   o_full             : all DEPTH entries occupied
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module cvt_rsp_fifo
    import cvt_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = cvt_rsp_t
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_push,
    input  T     i_din,
    input  logic i_pop,
    output logic o_valid,
    output T     o_dout,
    output logic o_full
);

    localparam int PTR_W = $clog2(DEPTH);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_valid = (r_cnt != '0);
    assign o_full  = (r_cnt == (PTR_W+1)'(DEPTH));
    assign o_dout  = r_mem[r_rptr];

    assign w_do_pop  = i_pop & o_valid;
    // When full, a push is only legal alongside a pop: the head is read
    // before the edge, so reusing its slot in the same cycle is safe.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + (PTR_W+1)'(1);
                2'b01:   r_cnt <= r_cnt - (PTR_W+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/cvt_issue_ctrl.sv
// cvt_issue_ctrl: issue/collect controller around the non-stallable itof unit.
// Requests are admitted only while a FIFO slot is reserved for them (credit =
// accepted but not yet popped), so a result leaving the converter always has
// room even if the writeback side stalls.
// Ports:
//   sys_clk, rstn                  : clock, synchronous active-low reset
//   req_valid/ready/data/tag       : tagged conversion request
//   cvt_valid, cvt_x               : to converter (combinational from request)
//   cvt_y, cvt_out_valid           : from converter
//   rsp_valid/ready/data/tag       : tagged float result, in acceptance order
//   err                            : sticky protocol error
// Build option: CVT_ISSUE_CHECK_EN enables the err checker and assertions;
// when undefined err is tied to 0.
module cvt_issue_ctrl
    import cvt_pkg::*;
#(
    parameter int UNIT_LAT   = UNIT_LAT_ITOF,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = TAG_W_DFLT
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_data,
    input  logic [TAG_W-1:0] req_tag,
    output logic             cvt_valid,
    output logic [31:0]      cvt_x,
    input  logic [31:0]      cvt_y,
    input  logic             cvt_out_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             err
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    logic [OCC_W-1:0]                r_occ;
    logic [UNIT_LAT-1:0]             r_tp_vld;
    logic [UNIT_LAT-1:0][TAG_W-1:0]  r_tp_tag;
    logic                            w_accept;
    logic                            w_pop;
    logic                            w_full;
    cvt_rsp_t                        w_push_ent;
    cvt_rsp_t                        w_head;

    // Credit check looks at registered occupancy only, never at rsp_ready.
    assign req_ready = rstn && (r_occ < OCC_W'(FIFO_DEPTH));
    assign w_accept  = req_valid & req_ready;
    assign cvt_valid = w_accept;
    assign cvt_x     = req_data;
    assign w_pop     = rsp_valid & rsp_ready;

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            r_occ <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Tag pipe tracks the converter stage by stage; it never stalls because
    // the converter cannot.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            r_tp_vld <= '0;
        end else begin
            r_tp_vld[0] <= w_accept;
            for (int i = 1; i < UNIT_LAT; i++) r_tp_vld[i] <= r_tp_vld[i-1];
        end
    end

    always_ff @(posedge sys_clk) begin
        r_tp_tag[0] <= req_tag;
        for (int i = 1; i < UNIT_LAT; i++) r_tp_tag[i] <= r_tp_tag[i-1];
    end

    always_comb begin
        w_push_ent      = '0;
        w_push_ent.data = cvt_y;
        w_push_ent.tag  = tag_t'(r_tp_tag[UNIT_LAT-1]);
    end

    cvt_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (cvt_rsp_t)
    ) u_fifo (
        .i_clk   (sys_clk),
        .i_rstn  (rstn),
        .i_push  (cvt_out_valid),
        .i_din   (w_push_ent),
        .i_pop   (w_pop),
        .o_valid (rsp_valid),
        .o_dout  (w_head),
        .o_full  (w_full)
    );

    assign rsp_data = w_head.data;
    assign rsp_tag  = TAG_W'(w_head.tag);

`ifdef CVT_ISSUE_CHECK_EN
    logic r_err;
    logic w_err_evt;

    assign w_err_evt = (cvt_out_valid != r_tp_vld[UNIT_LAT-1])
                     | (cvt_out_valid & w_full & ~w_pop);

    always_ff @(posedge sys_clk) begin
        if (!rstn)          r_err <= 1'b0;
        else if (w_err_evt) r_err <= 1'b1;
    end

    assign err = r_err;

    a_tail_vld: assert property (@(posedge sys_clk) disable iff (!rstn)
        cvt_out_valid == r_tp_vld[UNIT_LAT-1])
        else $warning("cvt_out_valid disagrees with tag pipe");

    a_no_ovf: assert property (@(posedge sys_clk) disable iff (!rstn)
        !(cvt_out_valid && w_full && !w_pop))
        else $warning("push into full response FIFO without pop");
`else
    logic w_unused;
    assign w_unused = &{1'b0, w_full, r_tp_vld[UNIT_LAT-1]};
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_cvt_issue_ctrl.sv
// Bench for cvt_issue_ctrl with a 2-cycle itof converter model attached.
module tb_cvt_issue_ctrl;

    localparam int TAG_W = 5;

    logic             sys_clk = 1'b0;
    logic             rstn;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_data;
    logic [TAG_W-1:0] req_tag;
    logic             cvt_valid;
    logic [31:0]      cvt_x;
    logic [31:0]      cvt_y;
    logic             cvt_out_valid;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             err;

    always #5 sys_clk = ~sys_clk;

    cvt_issue_ctrl #(.UNIT_LAT(2), .FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
        .sys_clk       (sys_clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_tag       (req_tag),
        .cvt_valid     (cvt_valid),
        .cvt_x         (cvt_x),
        .cvt_y         (cvt_y),
        .cvt_out_valid (cvt_out_valid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_tag       (rsp_tag),
        .err           (err)
    );

    // int32 -> float32, round to nearest even
    function automatic logic [31:0] itof(input logic [31:0] x);
        logic        s;
        logic [31:0] m;
        logic [63:0] mant, rem, half;
        logic [7:0]  e;
        int          p, sh;
        if (x == 32'd0) return 32'd0;
        s = x[31];
        m = s ? (~x + 32'd1) : x;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        e = 8'(127 + p);
        if (p <= 23) begin
            mant = 64'(m) << (23 - p);
        end else begin
            sh   = p - 23;
            mant = 64'(m) >> sh;
            rem  = 64'(m) & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
            if (mant[24]) begin
                mant = mant >> 1;
                e    = e + 8'd1;
            end
        end
        return {s, e, mant[22:0]};
    endfunction

    // converter model: stage1 registers x, stage2 holds the result
    logic        s1_v, s2_v, spur;
    logic [31:0] s1_x, s2_y;
    always @(posedge sys_clk) begin
        if (!rstn) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= cvt_valid;
            s2_v <= s1_v;
        end
    end
    always @(posedge sys_clk) begin
        s1_x <= cvt_x;
        s2_y <= itof(s1_x);
    end
    assign cvt_out_valid = s2_v | spur;
    assign cvt_y         = s2_y;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rx    = 0;
    logic [36:0] q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    // called at negedge: record accepts, check pops against the model queue
    task automatic mon();
        if (req_valid && req_ready) q.push_back({itof(req_data), req_tag});
        if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                chk("sb_extra", 64'(q.size()), 64'd1);
            end else begin
                chk("sb_data", 64'(rsp_data), 64'(q[0][36:5]));
                chk("sb_tag",  64'(rsp_tag),  64'(q[0][4:0]));
                void'(q.pop_front());
            end
            n_rx++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, sent, stale;
        logic [31:0] vdat [12];
        vdat = '{32'd7, 32'hFFFFFFFF, 32'd123456789, 32'h80000000, 32'd16777219, 32'd0,
                 32'd255, 32'hFFFF0000, 32'd1024, 32'd33554435, 32'h7FFFFFFF, 32'd42};

        // reset state, with a request pending
        rstn = 1'b0; req_valid = 1'b1; req_data = 32'd9; req_tag = 5'd1;
        rsp_ready = 1'b1; spur = 1'b0;
        cyc(); cyc();
        @(negedge sys_clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_cvt_valid", 64'(cvt_valid), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_err",       64'(err),       64'd0);
        cyc();
        rstn = 1'b1; req_valid = 1'b0;
        cyc();

        // single request, 3-cycle latency
        req_valid = 1'b1; req_data = 32'd1; req_tag = 5'd3;
        @(negedge sys_clk);
        chk("one_cvt_valid", 64'(cvt_valid), 64'd1);
        chk("one_cvt_x",     64'(cvt_x),     64'd1);
        chk("one_req_ready", 64'(req_ready), 64'd1);
        cyc();
        req_valid = 1'b0;
        @(negedge sys_clk); chk("one_lat1", 64'(rsp_valid), 64'd0); cyc();
        @(negedge sys_clk); chk("one_lat2", 64'(rsp_valid), 64'd0); cyc();
        @(negedge sys_clk);
        chk("one_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("one_rsp_data",  64'(rsp_data),  64'h3F800000);
        chk("one_rsp_tag",   64'(rsp_tag),   64'd3);
        cyc();
        @(negedge sys_clk); chk("one_popped", 64'(rsp_valid), 64'd0); cyc();

        // back-to-back requests
        req_valid = 1'b1; req_data = -32'sd5; req_tag = 5'd7;
        @(negedge sys_clk); chk("b2b_rdy0", 64'(req_ready), 64'd1); cyc();
        req_data = 32'd0; req_tag = 5'd8;
        @(negedge sys_clk); chk("b2b_rdy1", 64'(req_ready), 64'd1); cyc();
        req_data = 32'd16777217; req_tag = 5'd9;
        @(negedge sys_clk); chk("b2b_rdy2", 64'(req_ready), 64'd1); cyc();
        req_valid = 1'b0;
        @(negedge sys_clk);
        chk("b2b_v0", 64'(rsp_valid), 64'd1);
        chk("b2b_d0", 64'(rsp_data), 64'hC0A00000);
        chk("b2b_t0", 64'(rsp_tag), 64'd7);
        cyc();
        @(negedge sys_clk);
        chk("b2b_v1", 64'(rsp_valid), 64'd1);
        chk("b2b_d1", 64'(rsp_data), 64'h00000000);
        chk("b2b_t1", 64'(rsp_tag), 64'd8);
        cyc();
        @(negedge sys_clk);
        chk("b2b_v2", 64'(rsp_valid), 64'd1);
        chk("b2b_d2", 64'(rsp_data), 64'h4B800000);
        chk("b2b_t2", 64'(rsp_tag), 64'd9);
        cyc();

        // writeback stall: credit limits accepts to FIFO_DEPTH
        q.delete(); n_rx = 0; acc = 0;
        rsp_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_data = 32'(100 + acc); req_tag = 5'(10 + acc);
            @(negedge sys_clk);
            if (req_valid && req_ready) acc++;
            mon();
            cyc();
        end
        chk("stall_accepts", 64'(acc), 64'd4);
        @(negedge sys_clk); chk("stall_ready", 64'(req_ready), 64'd0);
        cyc();
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        chk("stall_pop_valid", 64'(rsp_valid), 64'd1);
        chk("stall_pop_nordy", 64'(req_ready), 64'd0);
        mon();
        cyc();
        rsp_ready = 1'b0; acc2 = 0;
        for (int i = 0; i < 6; i++) begin
            req_data = 32'(100 + acc + acc2); req_tag = 5'(10 + acc + acc2);
            @(negedge sys_clk);
            if (req_valid && req_ready) acc2++;
            mon();
            cyc();
        end
        chk("stall_one_more", 64'(acc2), 64'd1);
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 20 && (q.size() != 0 || rsp_valid); i++) begin
            @(negedge sys_clk); mon(); cyc();
        end
        chk("stall_rx", 64'(n_rx), 64'd5);

        // full FIFO with concurrent pop/accept, pointers wrap
        q.delete(); n_rx = 0; sent = 0;
        rsp_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 20 && sent < 4; i++) begin
            req_data = vdat[sent]; req_tag = 5'(sent + 16);
            @(negedge sys_clk);
            if (req_valid && req_ready) sent++;
            mon();
            cyc();
        end
        req_valid = 1'b0;
        cyc(); cyc(); cyc();
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && n_rx < 12; i++) begin
            req_valid = (sent < 12);
            if (sent < 12) begin
                req_data = vdat[sent]; req_tag = 5'(sent + 16);
            end
            @(negedge sys_clk);
            if (req_valid && req_ready) sent++;
            mon();
            cyc();
        end
        req_valid = 1'b0;
        chk("wrap_rx",   64'(n_rx), 64'd12);
        chk("wrap_left", 64'(q.size()), 64'd0);

        // reset with 2 buffered and 2 in flight
        rsp_ready = 1'b0; req_valid = 1'b1; acc = 0;
        for (int i = 0; i < 4; i++) begin
            req_data = 32'(500 + i); req_tag = 5'(i);
            @(negedge sys_clk);
            if (req_valid && req_ready) acc++;
            cyc();
        end
        chk("mid_accepts", 64'(acc), 64'd4);
        req_valid = 1'b0; rstn = 1'b0;
        @(negedge sys_clk); chk("mid_pre_buf", 64'(rsp_valid), 64'd1);
        cyc();
        rstn = 1'b1; rsp_ready = 1'b1;
        @(negedge sys_clk);
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_req_ready", 64'(req_ready), 64'd1);
        cyc();
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            if (rsp_valid) stale++;
            cyc();
        end
        chk("mid_stale", 64'(stale), 64'd0);

`ifdef CVT_ISSUE_CHECK_EN
        spur = 1'b1;
        @(negedge sys_clk); chk("err_before", 64'(err), 64'd0);
        cyc();
        spur = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk); chk("err_held", 64'(err), 64'd1); cyc();
        end
        rstn = 1'b0; cyc(); rstn = 1'b1;
        @(negedge sys_clk); chk("err_cleared", 64'(err), 64'd0);
        cyc();
`else
        @(negedge sys_clk); chk("err_tied", 64'(err), 64'd0);
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
